// File: rtl/sdma_write_engine.sv
// SDMA write engine: pops 32-bit words from the DAT word buffer and writes them to system memory,
// one outstanding request at a time. Boundary stop/resume is built only when SDMA_BOUNDARY_EN is defined.
module sdma_write_engine #(
  parameter int AddrWidth  = 32,
  parameter int CountWidth = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [AddrWidth-1:0]  sys_addr_i,
  input  logic [CountWidth-1:0] total_words_i,
  input  logic [2:0]            boundary_i,
  input  logic                  resume_i,
  input  logic [AddrWidth-1:0]  resume_addr_i,
  input  logic                  word_valid_i,
  input  logic [31:0]           word_data_i,
  output logic                  word_ready_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [AddrWidth-1:0]  mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_rsp_valid_i,
  input  logic                  mem_err_i,
  output logic [AddrWidth-1:0]  sys_addr_o,
  output logic                  dma_int_o,
  output logic                  done_o,
  output logic                  adma_err_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetch    = 3'd1,
    StReq      = 3'd2,
    StRsp      = 3'd3,
    StDone     = 3'd4,
    StError    = 3'd5
`ifdef SDMA_BOUNDARY_EN
    , StBoundary = 3'd6
`endif
  } state_e;

  state_e                state_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [CountWidth-1:0] cnt_q;
  logic [31:0]           data_q;
  logic [AddrWidth-1:0]  addr_inc_d;

  assign addr_inc_d = addr_q + AddrWidth'(4);

`ifdef SDMA_BOUNDARY_EN
  logic                 dma_int_q;
  logic [AddrWidth-1:0] bnd_mask;
  logic                 bnd_hit;
  logic                 unused_bits;

  // boundary_i is used live so software may change it between stops
  assign bnd_mask    = (AddrWidth'(1) << (12 + int'(boundary_i))) - AddrWidth'(1);
  assign bnd_hit     = (addr_inc_d & bnd_mask) == '0;
  assign unused_bits = ^{sys_addr_i[1:0], resume_addr_i[1:0]};
  assign dma_int_o   = dma_int_q;
`else
  logic unused_bits;

  assign unused_bits = ^{sys_addr_i[1:0], resume_addr_i, resume_i, boundary_i};
  assign dma_int_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
`ifdef SDMA_BOUNDARY_EN
      dma_int_q <= 1'b0;
`endif
    end else if (abort_i) begin
      state_q   <= StIdle;
`ifdef SDMA_BOUNDARY_EN
      dma_int_q <= 1'b0;
`endif
    end else begin
`ifdef SDMA_BOUNDARY_EN
      dma_int_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (start_i) begin
            addr_q  <= {sys_addr_i[AddrWidth-1:2], 2'b00};
            cnt_q   <= total_words_i;
            state_q <= (total_words_i == '0) ? StDone : StFetch;
          end
        end
        StFetch: begin
          if (word_valid_i) begin
            data_q  <= word_data_i;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (mem_gnt_i) state_q <= StRsp;
        end
        StRsp: begin
          if (mem_rsp_valid_i) begin
            if (mem_err_i) begin
              state_q <= StError;
            end else begin
              addr_q <= addr_inc_d;
              if (cnt_q != '0) cnt_q <= cnt_q - CountWidth'(1);
              // Completion wins over a boundary hit on the final word
              if (cnt_q == CountWidth'(1)) begin
                state_q <= StDone;
`ifdef SDMA_BOUNDARY_EN
              end else if (bnd_hit) begin
                state_q   <= StBoundary;
                dma_int_q <= 1'b1;
`endif
              end else begin
                state_q <= StFetch;
              end
            end
          end
        end
`ifdef SDMA_BOUNDARY_EN
        StBoundary: begin
          if (resume_i) begin
            addr_q  <= {resume_addr_i[AddrWidth-1:2], 2'b00};
            state_q <= StFetch;
          end
        end
`endif
        StDone:  state_q <= StIdle;
        StError: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign word_ready_o = (state_q == StFetch);
  assign mem_req_o    = (state_q == StReq);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = data_q;
  assign sys_addr_o   = addr_q;
  assign done_o       = (state_q == StDone);
  assign adma_err_o   = (state_q == StError);
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_sdma_write_engine.sv
// Testbench for sdma_write_engine: directed and randomized transfers against a word-level
// reference model of the expected write stream, pulses and final address.
module tb_sdma_write_engine;

`ifdef SDMA_BOUNDARY_EN
  localparam bit BndEn = 1'b1;
`else
  localparam bit BndEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        abort_i;
  logic [31:0] sys_addr_i;
  logic [24:0] total_words_i;
  logic [2:0]  boundary_i;
  logic        resume_i;
  logic [31:0] resume_addr_i;
  logic        word_valid_i;
  logic [31:0] word_data_i;
  logic        word_ready_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rsp_valid_i;
  logic        mem_err_i;
  logic [31:0] sys_addr_o;
  logic        dma_int_o;
  logic        done_o;
  logic        adma_err_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] res_list [8];

  sdma_write_engine #(.AddrWidth(32), .CountWidth(25)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .sys_addr_i(sys_addr_i), .total_words_i(total_words_i), .boundary_i(boundary_i),
    .resume_i(resume_i), .resume_addr_i(resume_addr_i),
    .word_valid_i(word_valid_i), .word_data_i(word_data_i), .word_ready_o(word_ready_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_err_i(mem_err_i),
    .sys_addr_o(sys_addr_o), .dma_int_o(dma_int_o), .done_o(done_o),
    .adma_err_o(adma_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; abort_i = 1'b0; resume_i = 1'b0; resume_addr_i = '0;
    word_valid_i = 1'b0; word_data_i = '0; mem_gnt_i = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_err_i = 1'b0;
  endtask

  task automatic fill_res();
    for (int i = 0; i < 8; i++) res_list[i] = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":word_ready"}, 32'(word_ready_o), 32'd0);
    check({tag, ":mem_req"},    32'(mem_req_o),    32'd0);
    check({tag, ":dma_int"},    32'(dma_int_o),    32'd0);
    check({tag, ":done"},       32'(done_o),       32'd0);
    check({tag, ":adma_err"},   32'(adma_err_o),   32'd0);
    check({tag, ":busy"},       32'(busy_o),       32'd0);
    check({tag, ":mem_addr"},   mem_addr_o,        32'd0);
    check({tag, ":sys_addr"},   sys_addr_o,        32'd0);
    check({tag, ":mem_wdata"},  mem_wdata_o,       32'd0);
  endtask

  // Runs one transfer with a combined buffer source / memory responder / software agent,
  // then compares the observed write stream against the reference model.
  task automatic run_xfer(input logic [31:0] saddr, input int n, input logic [2:0] bnd,
                          input int err_idx, input int stall_idx, input int stall_len,
                          input bit rnd, input string tag);
    logic [31:0] src[$];
    logic [31:0] exp_a[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [31:0] a, hold_a, hold_d;
    int nw, stops, pops, dones, errs, ints, cyc, post, stall_cnt, res_wait, rsp_wait, nchk;
    bit pend, hold, has_err;

    for (int i = 0; i < n + 4; i++) src.push_back($urandom);

    // Reference: walk the word addresses, jumping to the next resume address at each boundary stop
    has_err = (err_idx >= 0) && (err_idx < n);
    nw = has_err ? err_idx + 1 : n;
    a = saddr & 32'hFFFF_FFFC;
    stops = 0;
    for (int i = 0; i < nw; i++) begin
      exp_a.push_back(a);
      if (has_err && i == err_idx) break;
      a = a + 32'd4;
      if (i == n - 1) break;
      if (BndEn && (a % (32'd4096 << bnd)) == 32'd0) begin
        a = res_list[(stops < 8) ? stops : 7] & 32'hFFFF_FFFC;
        stops++;
      end
    end

    @(negedge clk);
    idle_inputs();
    sys_addr_i = saddr; total_words_i = n[24:0]; boundary_i = bnd; start_i = 1'b1;
    pops = 0; dones = 0; errs = 0; ints = 0; cyc = 0; post = -1;
    stall_cnt = 0; res_wait = 0; rsp_wait = 0; pend = 1'b0; hold = 1'b0;
    hold_a = '0; hold_d = '0;

    while (post != 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      idle_inputs();
      mem_err_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (post > 0) post--;
      if (cyc == 1 && n > 0) check({tag, ":ready_after_start"}, 32'(word_ready_o), 32'd1);
      if (hold) begin
        check({tag, ":req_held"},   32'(mem_req_o), 32'd1);
        check({tag, ":addr_held"},  mem_addr_o,     hold_a);
        check({tag, ":wdata_held"}, mem_wdata_o,    hold_d);
      end
      if (done_o) dones++;
      if (adma_err_o) errs++;
      if ((done_o || adma_err_o) && post < 0) post = 3;
      if (res_wait > 0) begin
        res_wait--;
        if (res_wait == 0) begin
          resume_i = 1'b1;
          resume_addr_i = res_list[(ints - 1 < 8) ? ints - 1 : 7];
        end
      end
      if (dma_int_o) begin
        ints++;
        res_wait = rnd ? $urandom_range(1, 4) : 1;
      end
      word_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      word_data_i = (pops < src.size()) ? src[pops] : 32'h0;
      if (word_ready_o && word_valid_i) pops++;
      if (pend) begin
        if (rsp_wait == 0) begin
          mem_rsp_valid_i = 1'b1;
          mem_err_i = (wr_a.size() - 1 == err_idx);
          pend = 1'b0;
        end else begin
          rsp_wait--;
        end
      end
      hold = 1'b0;
      if (mem_req_o) begin
        mem_gnt_i = 1'b1;
        if (wr_a.size() == stall_idx && stall_cnt < stall_len) begin
          mem_gnt_i = 1'b0;
          stall_cnt++;
        end else if (rnd && $urandom_range(0, 2) == 0) begin
          mem_gnt_i = 1'b0;
        end
        if (mem_gnt_i) begin
          wr_a.push_back(mem_addr_o);
          wr_d.push_back(mem_wdata_o);
          pend = 1'b1;
          rsp_wait = rnd ? $urandom_range(0, 2) : 0;
        end else begin
          hold = 1'b1; hold_a = mem_addr_o; hold_d = mem_wdata_o;
        end
      end
    end
    @(negedge clk);
    idle_inputs();

    check({tag, ":finished"}, 32'(post == 0), 32'd1);
    check({tag, ":nwrites"}, 32'(wr_a.size()), 32'(exp_a.size()));
    nchk = (wr_a.size() < exp_a.size()) ? wr_a.size() : exp_a.size();
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s:waddr%0d", tag, i), wr_a[i], exp_a[i]);
      check($sformatf("%s:wdata%0d", tag, i), wr_d[i], src[i]);
    end
    check({tag, ":done_cnt"}, 32'(dones), has_err ? 32'd0 : 32'd1);
    check({tag, ":err_cnt"},  32'(errs),  has_err ? 32'd1 : 32'd0);
    check({tag, ":int_cnt"},  32'(ints),  32'(stops));
    check({tag, ":pops"},     32'(pops),  32'(nw));
    check({tag, ":sys_addr"}, sys_addr_o, a);
    check({tag, ":busy_end"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [31:0] base;
    int n, sz, ei;
    logic [2:0] b;

    idle_inputs();
    sys_addr_i = '0; total_words_i = '0; boundary_i = '0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_ni = 1'b1;
    fill_res();

    run_xfer(32'h1000_0000, 128, 3'd0, -1, -1, 0, 1'b0, "basic");

    res_list[0] = 32'h2000_0000;
    run_xfer(32'h0000_0FF8, 4, 3'd0, -1, -1, 0, 1'b0, "boundary");

    fill_res();
    run_xfer(32'h0000_4000, 6, 3'd0, -1, 2, 5, 1'b0, "gnt_stall");
    run_xfer(32'h0000_8000, 4, 3'd0, 1, -1, 0, 1'b0, "mem_err");
    run_xfer(32'h0000_C000, 0, 3'd0, -1, -1, 0, 1'b0, "zero_len");

    // Abort while a request is being granted; a late error response must be ignored
    @(negedge clk);
    sys_addr_i = 32'h3000_0000; total_words_i = 25'd4; start_i = 1'b1;
    word_valid_i = 1'b1; word_data_i = 32'hA5A5_0001;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    word_valid_i = 1'b0;
    check("abort:req",   32'(mem_req_o), 32'd1);
    check("abort:addr",  mem_addr_o,     32'h3000_0000);
    check("abort:wdata", mem_wdata_o,    32'hA5A5_0001);
    abort_i = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; mem_gnt_i = 1'b0;
    check("abort:busy", 32'(busy_o),    32'd0);
    check("abort:req0", 32'(mem_req_o), 32'd0);
    mem_rsp_valid_i = 1'b1; mem_err_i = 1'b1;
    @(negedge clk);
    mem_rsp_valid_i = 1'b0; mem_err_i = 1'b0;
    check("abort_late:busy",  32'(busy_o),       32'd0);
    check("abort_late:err",   32'(adma_err_o),   32'd0);
    check("abort_late:done",  32'(done_o),       32'd0);
    check("abort_late:ready", 32'(word_ready_o), 32'd0);

    // Reset for one edge while waiting for a response
    @(negedge clk);
    sys_addr_i = 32'h4000_0010; total_words_i = 25'd3; start_i = 1'b1;
    word_valid_i = 1'b1; word_data_i = 32'h1234_5678;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    word_valid_i = 1'b0;
    check("rstmid:req", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    check("rstmid:in_rsp", 32'(busy_o & ~mem_req_o & ~word_ready_o), 32'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    check_all_zero("rstmid");

    run_xfer(32'hFFFF_FFFC, 2, 3'd0, -1, -1, 0, 1'b0, "wrap");

    for (int k = 0; k < 8; k++) begin
      fill_res();
      b = 3'($urandom_range(0, 1));
      sz = 4096 << b;
      base = ($urandom & ~(32'(sz) - 32'd1)) + 32'(sz) - 32'(4 * $urandom_range(1, 16));
      n = $urandom_range(1, 40);
      ei = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_xfer(base, n, b, ei, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1,
               $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
